// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the staged reset controller.
package rst_seq_pkg;

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

  localparam int         DEF_NUM_SRC         = 4;
  localparam int         DEF_NUM_OUT         = 3;
  localparam logic [3:0] DEF_SRC_ACT_LOW     = 4'b0001;
  localparam logic [3:0] DEF_FAST_ASSERT     = 4'b1111;
  localparam int         DEF_DEBOUNCE_CYCLES = 100000;
  localparam int         DEF_MIN_HOLD        = 1000;
  localparam int         DEF_STAGE_DELAY     = 1000;
  localparam int         DEF_CNT_W           = 32;

  // Raw pin level that means "asserted" for a source of the given polarity.
  function automatic logic asserted_level(input logic act_low);
    return ~act_low;
  endfunction

endpackage

// File: rtl/rst_src_debounce.sv
// One reset source: 2-flop synchroniser, polarity normalise, debounce with
// optional fast-assert bypass. deb is 1 while the source counts as asserted.
module rst_src_debounce
  import rst_seq_pkg::*;
#(
  parameter logic ACT_LOW         = 1'b0,
  parameter logic FAST            = 1'b0,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic src_in,
  output logic deb
);

  logic             sync1;
  logic             sync2;
  logic             sync_n;
  logic [CNT_W-1:0] cnt;

  assign sync_n = sync2 ^ ACT_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= asserted_level(ACT_LOW);
      sync2 <= asserted_level(ACT_LOW);
      cnt   <= '0;
      deb   <= 1'b1;
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
      if (FAST && sync_n) begin
        deb <= 1'b1;
        cnt <= '0;
      end else if (sync_n != deb) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync_n;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset controller: combines debounced sources, holds all domains for a
// minimum time, then releases them in order with a fixed stagger.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int                 NUM_SRC         = DEF_NUM_SRC,
  parameter int                 NUM_OUT         = DEF_NUM_OUT,
  parameter logic [NUM_SRC-1:0] SRC_ACT_LOW     = NUM_SRC'(DEF_SRC_ACT_LOW),
  parameter logic [NUM_SRC-1:0] FAST_ASSERT     = NUM_SRC'(DEF_FAST_ASSERT),
  parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                 MIN_HOLD        = DEF_MIN_HOLD,
  parameter int                 STAGE_DELAY     = DEF_STAGE_DELAY,
  parameter int                 CNT_W           = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               seq_done,
  output logic [NUM_SRC-1:0] cause
);

  logic [NUM_SRC-1:0] deb;
  logic [NUM_SRC-1:0] active;
  logic               req;
  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   stage_cnt;
  logic [CNT_W-1:0]   stage_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    rst_src_debounce #(
      .ACT_LOW        (SRC_ACT_LOW[i]),
      .FAST           (FAST_ASSERT[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .src_in(src_in[i]),
      .deb   (deb[i])
    );
  end

  assign active = deb & ~src_mask;
  assign req    = |active;

  // The hold counter saturates at its threshold so a long-held request
  // cannot wrap it back below MIN_HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      stage_idx <= '0;
    end else if (req && state != ASSERT) begin
      state     <= ASSERT;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      stage_idx <= '0;
    end else begin
      case (state)
        ASSERT: begin
          if (hold_cnt >= CNT_W'(MIN_HOLD - 1) && !req) begin
            state     <= RELEASE;
            stage_cnt <= '0;
            stage_idx <= '0;
          end else if (hold_cnt < CNT_W'(MIN_HOLD - 1)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (stage_cnt == CNT_W'(STAGE_DELAY - 1)) begin
            rst_out   <= rst_out << 1;
            stage_cnt <= '0;
            if (stage_idx == CNT_W'(NUM_OUT - 1)) begin
              state     <= RUN;
              seq_done  <= 1'b1;
              stage_idx <= '0;
            end else begin
              stage_idx <= stage_idx + CNT_W'(1);
            end
          end else begin
            stage_cnt <= stage_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          rst_out  <= '0;
          seq_done <= 1'b1;
        end
        default: state <= ASSERT;
      endcase
    end
  end

  // A set on the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause <= '0;
    end else begin
      cause <= (cause & {NUM_SRC{~cause_clr}}) | active;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output transitions are queued
// with their cycle number and matched against observed changes.
module tb_rst_seq_ctrl;

  localparam logic [3:0] IDLE = 4'b0001;

  logic       system_clk_100_internal = 1'b0;
  logic       reset;
  logic [3:0] src_in;
  logic [3:0] src_mask;
  logic       cause_clr;
  logic [2:0] rst_out;
  logic       seq_done;
  logic [3:0] cause;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    mon_en   = 1'b0;
  logic [3:0] mon_prev;
  string cur_test = "none";

  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       done;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  rst_seq_ctrl #(
    .NUM_SRC        (4),
    .NUM_OUT        (3),
    .SRC_ACT_LOW    (4'b0001),
    .FAST_ASSERT    (4'b0001),
    .DEBOUNCE_CYCLES(8),
    .MIN_HOLD       (16),
    .STAGE_DELAY    (4),
    .CNT_W          (32)
  ) dut (
    .clk      (system_clk_100_internal),
    .reset    (reset),
    .src_in   (src_in),
    .src_mask (src_mask),
    .cause_clr(cause_clr),
    .rst_out  (rst_out),
    .seq_done (seq_done),
    .cause    (cause)
  );

  always #5 system_clk_100_internal = ~system_clk_100_internal;
  always @(posedge system_clk_100_internal) cyc <= cyc + 1;

  // Every change of {rst_out, seq_done} must match the next queued event.
  always @(negedge system_clk_100_internal) begin
    if (mon_en && {rst_out, seq_done} !== mon_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_unexpected cyc=%0d rst_out=%b seq_done=%b required=no change",
                 cur_test, cyc, rst_out, seq_done);
      end else begin
        mon_ev = exp_q.pop_front();
        if (cyc != mon_ev.at || rst_out !== mon_ev.rst || seq_done !== mon_ev.done) begin
          failures++;
          $display("FAIL %s_event got cyc=%0d rst_out=%b seq_done=%b required cyc=%0d rst_out=%b seq_done=%b",
                   cur_test, cyc, rst_out, seq_done, mon_ev.at, mon_ev.rst, mon_ev.done);
        end
      end
      mon_prev = {rst_out, seq_done};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge system_clk_100_internal);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic [2:0] r, input logic d);
    exp_q.push_back('{at: at, rst: r, done: d});
  endtask

  task automatic wait_events(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic pulse_clr();
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1; src_in = IDLE; src_mask = '0; cause_clr = 1'b0;
    tick(3);
    checks++;
    if (rst_out !== 3'b111) begin
      failures++; $display("FAIL reset_rst_out got=%b required=111", rst_out);
    end
    checks++;
    if (seq_done !== 1'b0) begin
      failures++; $display("FAIL reset_seq_done got=%b required=0", seq_done);
    end
    checks++;
    if (cause !== 4'b0000) begin
      failures++; $display("FAIL reset_cause got=%b required=0000", cause);
    end
    mon_prev = {rst_out, seq_done};
    mon_en = 1'b1;
  endtask

  task automatic test_power_up();
    int r;
    bit ok;
    cur_test = "power_up";
    r = cyc;
    reset = 1'b0;
    expect_ev(r + 20, 3'b110, 1'b0);
    expect_ev(r + 24, 3'b100, 1'b0);
    expect_ev(r + 28, 3'b000, 1'b1);
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL power_up_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(5);
    checks++;
    if (cause !== 4'b1111) begin
      failures++; $display("FAIL power_up_cause got=%b required=1111", cause);
    end
    pulse_clr();
    checks++;
    if (cause !== 4'b0000) begin
      failures++; $display("FAIL power_up_cause_clr got=%b required=0000", cause);
    end
  endtask

  task automatic test_fast_glitch();
    int n;
    bit ok;
    cur_test = "fast_glitch";
    n = cyc;
    src_in[0] = 1'b0;
    expect_ev(n + 4,  3'b111, 1'b0);
    expect_ev(n + 24, 3'b110, 1'b0);
    expect_ev(n + 28, 3'b100, 1'b0);
    expect_ev(n + 32, 3'b000, 1'b1);
    tick(1);
    src_in[0] = 1'b1;
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL fast_glitch_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(8);
    checks++;
    if (cause !== 4'b0001) begin
      failures++; $display("FAIL fast_glitch_cause got=%b required=0001", cause);
    end
  endtask

  task automatic test_debounce();
    int n;
    bit ok;
    cur_test = "debounce";
    src_in[1] = 1'b1;
    tick(7);
    src_in[1] = 1'b0;
    tick(25);
    checks++;
    if (rst_out !== 3'b000 || seq_done !== 1'b1 || cause !== 4'b0001) begin
      failures++;
      $display("FAIL debounce_short got rst_out=%b seq_done=%b cause=%b required 000 1 0001",
               rst_out, seq_done, cause);
    end
    n = cyc;
    src_in[1] = 1'b1;
    expect_ev(n + 11, 3'b111, 1'b0);
    expect_ev(n + 31, 3'b110, 1'b0);
    expect_ev(n + 35, 3'b100, 1'b0);
    expect_ev(n + 39, 3'b000, 1'b1);
    tick(8);
    src_in[1] = 1'b0;
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL debounce_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(8);
  endtask

  task automatic test_mask();
    int n;
    int m;
    bit ok;
    cur_test = "mask";
    pulse_clr();
    n = cyc;
    src_mask = 4'b0010;
    src_in[1] = 1'b1;
    src_in[0] = 1'b0;
    expect_ev(n + 4,  3'b111, 1'b0);
    expect_ev(n + 24, 3'b110, 1'b0);
    expect_ev(n + 28, 3'b100, 1'b0);
    expect_ev(n + 32, 3'b000, 1'b1);
    tick(1);
    src_in[0] = 1'b1;
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mask_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(5);
    checks++;
    if (cause !== 4'b0001) begin
      failures++; $display("FAIL mask_cause got=%b required=0001", cause);
    end
    m = cyc;
    src_mask = 4'b0000;
    expect_ev(m + 1, 3'b111, 1'b0);
    tick(2);
    src_in[1] = 1'b0;
    expect_ev(m + 21, 3'b110, 1'b0);
    expect_ev(m + 25, 3'b100, 1'b0);
    expect_ev(m + 29, 3'b000, 1'b1);
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mask_unmask_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(5);
    checks++;
    if (cause !== 4'b0011) begin
      failures++; $display("FAIL mask_unmask_cause got=%b required=0011", cause);
    end
  endtask

  task automatic test_cause();
    int n;
    bit ok;
    cur_test = "cause";
    pulse_clr();
    checks++;
    if (cause !== 4'b0000) begin
      failures++; $display("FAIL cause_idle_clr got=%b required=0000", cause);
    end
    n = cyc;
    src_in[2] = 1'b1;
    expect_ev(n + 11, 3'b111, 1'b0);
    tick(15);
    pulse_clr();
    checks++;
    if (cause !== 4'b0100) begin
      failures++; $display("FAIL cause_set_wins got=%b required=0100", cause);
    end
    tick(4);
    src_in[2] = 1'b0;
    expect_ev(n + 35, 3'b110, 1'b0);
    expect_ev(n + 39, 3'b100, 1'b0);
    expect_ev(n + 43, 3'b000, 1'b1);
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL cause_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (cause !== 4'b0100) begin
      failures++; $display("FAIL cause_sticky got=%b required=0100", cause);
    end
    pulse_clr();
    checks++;
    if (cause !== 4'b0000) begin
      failures++; $display("FAIL cause_clr_after_drop got=%b required=0000", cause);
    end
    tick(5);
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    cur_test = "mid_reset";
    n = cyc;
    src_in[0] = 1'b0;
    expect_ev(n + 4,  3'b111, 1'b0);
    expect_ev(n + 24, 3'b110, 1'b0);
    expect_ev(n + 28, 3'b100, 1'b0);
    tick(1);
    src_in[0] = 1'b1;
    tick(27);
    checks++;
    if (rst_out !== 3'b100) begin
      failures++; $display("FAIL mid_reset_pre got=%b required=100", rst_out);
    end
    reset = 1'b1;
    expect_ev(n + 29, 3'b111, 1'b0);
    tick(1);
    checks++;
    if (rst_out !== 3'b111 || seq_done !== 1'b0 || cause !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_values got rst_out=%b seq_done=%b cause=%b required 111 0 0000",
               rst_out, seq_done, cause);
    end
    reset = 1'b0;
    expect_ev(n + 49, 3'b110, 1'b0);
    expect_ev(n + 53, 3'b100, 1'b0);
    expect_ev(n + 57, 3'b000, 1'b1);
    wait_events(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mid_reset_drain pending=%0d required=0", exp_q.size()); exp_q.delete();
    end
    tick(8);
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_fast_glitch();
    test_debounce();
    test_mask();
    test_cause();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset controller for the FPGA fabric of the HPS SoC top level. It synchronises and debounces several reset sources with per-source polarity, mask and fast-assert option, and holds all reset domains for a minimum time. It then releases NUM_OUT reset domains in a fixed order with a programmable stagger, and keeps a sticky record of which source caused the last reset. It replaces the single-input debounce and AND-combine of reset sources at the top level.

## Interface
- NUM_SRC, 4: number of reset sources; bit 0 is the board push-button.
- NUM_OUT, 3: number of sequenced reset outputs.
- SRC_ACT_LOW, 4'b0001: per-source polarity. A bit of 1 means that source is asserted when low.
- FAST_ASSERT, 4'b1111: per source, 1 means assertion bypasses debounce and only release is debounced.
- DEBOUNCE_CYCLES, 100000: cycles of stable mismatch needed before a debounced level changes (1 ms at 100 MHz).
- MIN_HOLD, 1000: minimum number of cycles spent in ASSERT.
- STAGE_DELAY, 1000: cycles between successive output releases.
- CNT_W, 32: width of every internal counter; must hold the largest of the three count parameters.
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: synchronous, active-high. Asserted on clk when sampled high.
- src_in, input, NUM_SRC: raw reset sources, asynchronous to clk.
- src_mask, input, NUM_SRC: a bit of 1 ignores that source. Synchronous to clk.
- cause_clr, input, 1: single-cycle pulse that clears cause.
- rst_out, output, NUM_OUT: active-high domain resets. Bit 0 is released first.
- seq_done, output, 1: high while in RUN, i.e. all domains released.
- cause, output, NUM_SRC: sticky per-source "caused reset" flags.

## Operation
- Per source:
  - 2-flop synchroniser, then normalise polarity so that asserted = 1.
  - Debouncer: if the synchronised value differs from the debounced value, the counter increments, otherwise it clears. The debounced value flips when the count reaches DEBOUNCE_CYCLES−1 with the mismatch still present.
  - With FAST_ASSERT[i], a 1 at the synchroniser output sets the debounced value on the next cycle and clears the counter.
- req = OR over i of (debounced[i] & ~src_mask[i]).
- FSM states:
  - ASSERT: rst_out all 1, seq_done=0. The hold counter counts up. Go to RELEASE when the hold counter ≥ MIN_HOLD−1 and req=0.
  - RELEASE: stage index k starts at 0 and the delay counter starts at 0. When the delay counter reaches STAGE_DELAY−1, rst_out[k] goes to 0, the counter clears and k increments. After k=NUM_OUT−1 is released, go to RUN.
  - RUN: rst_out all 0, seq_done=1.
- req=1 in RELEASE or RUN: go to ASSERT on the next cycle. All rst_out return to 1 together, seq_done drops, and the hold and stage counters clear.
- req=1 in ASSERT restarts nothing; the hold counter keeps counting.
- cause[i] is set on any cycle where debounced[i] & ~src_mask[i] is 1.
  - cause_clr clears all bits.
  - If a set and a clear happen in the same cycle on the same bit, the set wins.
- Changing src_mask takes effect on req in the same cycle. It has no effect on debounce state.

## Timing
- Values during and after reset:
  - rst_out all 1, seq_done 0, cause 0.
  - FSM in ASSERT, all counters 0.
  - Debounced values all 1 (asserted), so release after power-up always needs a full debounce period.
  - Synchroniser flops reset to the asserted level.
- Assert latency from a src_in edge to rst_out rising:
  - FAST_ASSERT source: 4 cycles (2 sync + 1 debounce + 1 FSM register).
  - Otherwise: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Release latency:
  - From entering RELEASE, rst_out[k] falls (k+1)·STAGE_DELAY cycles later.
  - seq_done rises on the same cycle as rst_out[NUM_OUT−1] falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- reset asserted mid-sequence returns the block to its reset values on the next edge, whatever the state.
- A src_in glitch shorter than DEBOUNCE_CYCLES on a non-fast source causes no change.
- A glitch on a fast source of at least 1 cycle at the synchroniser causes a full ASSERT of at least MIN_HOLD cycles.

## Structure
- Package rst_seq_pkg holds:
  - state_t enum {ASSERT, RELEASE, RUN}.
  - Default parameter constants.
- Sub-module rst_src_debounce, instantiated NUM_SRC times via generate. It contains the synchroniser, polarity normalise, debounce counter and fast-assert bypass. Parameters: ACT_LOW, FAST, DEBOUNCE_CYCLES, CNT_W.
- The top level holds the req OR-reduction, the FSM, the hold and stage counters, and the cause register.

## Test plan
Parameters for all scenarios: NUM_SRC=4, NUM_OUT=3, DEBOUNCE_CYCLES=8, MIN_HOLD=16, STAGE_DELAY=4, SRC_ACT_LOW=4'b0001, FAST_ASSERT=4'b0001. Sources are idle unless stated.

1. Power-up: reset for 3 cycles, then release → rst_out=3'b111 for ≥16 cycles; bits 0, 1, 2 fall at 4, 8, 12 cycles after entering RELEASE; seq_done=1 with bit 2.
2. In RUN, src_in[0] low for 1 cycle → rst_out=3'b111 four cycles later and seq_done=0. ASSERT lasts ≥16 cycles, then the full release sequence repeats. cause=4'b0001.
3. In RUN, src_in[1] high for 7 cycles → no change. High for 8 cycles → ASSERT entered 11 cycles after the edge.
4. src_mask=4'b0010 with src_in[1] held high → the sequence completes and cause[1] stays 0. Clearing the mask → ASSERT on the next cycle.
5. cause=4'b0100 with cause_clr pulsed in the same cycle that source 2 is still set → cause stays 4'b0100. cause_clr after source 2 drops → cause becomes 0.
6. reset pulsed when rst_out=3'b100 (mid-RELEASE) → next cycle rst_out=3'b111, seq_done=0 and cause=0, and a full debounce, hold and release follows.
